// File: rtl/issue_ctrl.sv
// Issue controller: streams eight latched 8-bit instructions into a 5-stage pipeline,
// inserting NOP bubbles on register hazards. Define ISSUE_FORWARD_EN for the forwarding variant.
module issue_ctrl #(
   parameter logic [7:0] NOP_CODE = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [63:0] instr_bits,
   input  logic        pipe_ready,
   output logic [7:0]  issue_instr,
   output logic        issue_valid,
   output logic        issue_bubble,
   output logic        busy,
   output logic        done,
   output logic [4:0]  bubble_cnt
);

   // state | meaning
   // IDLE  | waiting for load
   // ISSUE | presenting instr[idx] or a bubble each cycle
   // DONE  | one-cycle done pulse, then back to IDLE
   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t      state, state_nx;
   logic [63:0] prog;
   logic [2:0]  idx;
   logic [4:0]  bub_cnt;
   logic        s1_v;
   logic [2:0]  s1_d;
`ifndef ISSUE_FORWARD_EN
   logic        s2_v;
   logic [2:0]  s2_d;
`endif

   logic [5:0]  sel;
   logic [7:0]  cur;
   logic [1:0]  op;
   logic [2:0]  fld_a, fld_b;
   logic        rd_a, rd_b, hit_a, hit_b, hazard, xfer;

   assign sel   = {3'd7 - idx, 3'b000};
   assign cur   = prog[sel +: 8];
   assign op    = cur[7:6];
   assign fld_a = cur[5:3];
   assign fld_b = cur[2:0];
   assign rd_a  = (op != 2'b00);
   assign rd_b  = (op == 2'b10);

`ifdef ISSUE_FORWARD_EN
   // With forwarding only a load result one slot back can stall, so S1 holds lw destinations only.
   assign hit_a = s1_v && (s1_d == fld_a);
   assign hit_b = s1_v && (s1_d == fld_b);
`else
   assign hit_a = (s1_v && (s1_d == fld_a)) || (s2_v && (s2_d == fld_a));
   assign hit_b = (s1_v && (s1_d == fld_b)) || (s2_v && (s2_d == fld_b));
`endif

   assign hazard = (rd_a && hit_a) || (rd_b && hit_b);
   assign xfer   = (state == ISSUE) && pipe_ready;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (load) state_nx = ISSUE;
         ISSUE:   if (pipe_ready && !hazard && (idx == 3'd7)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         prog    <= 64'h0;
         idx     <= 3'd0;
         bub_cnt <= 5'd0;
         s1_v    <= 1'b0;
         s1_d    <= 3'd0;
`ifndef ISSUE_FORWARD_EN
         s2_v    <= 1'b0;
         s2_d    <= 3'd0;
`endif
      end else begin
         state <= state_nx;
         if ((state == IDLE) && load) begin
            prog    <= instr_bits;
            idx     <= 3'd0;
            bub_cnt <= 5'd0;
            s1_v    <= 1'b0;
`ifndef ISSUE_FORWARD_EN
            s2_v    <= 1'b0;
`endif
         end else if (xfer) begin
`ifdef ISSUE_FORWARD_EN
            s1_v <= !hazard && (op == 2'b11);
`else
            s2_v <= s1_v;
            s2_d <= s1_d;
            s1_v <= !hazard && cur[6];
`endif
            s1_d <= fld_b;
            if (hazard) begin
               if (bub_cnt != 5'd31) bub_cnt <= bub_cnt + 5'd1;
            end else begin
               idx <= idx + 3'd1;
            end
         end
      end
   end

   assign issue_valid  = (state == ISSUE);
   assign issue_bubble = issue_valid && hazard;
   assign issue_instr  = (issue_valid && !hazard) ? cur : NOP_CODE;
   assign busy         = (state == ISSUE);
   assign done         = (state == DONE);
   assign bubble_cnt   = bub_cnt;

endmodule
